lc3b_bht: RTL



---
 rtl/lc3b_bht_if.sv | 28 ++
 rtl/lc3b_bht.sv | 74 +++++++
 2 files changed

// File: rtl/lc3b_bht_if.sv
// Fetch/resolve-side bundle for the LC-3b branch history table.
// master = pipeline (drives lookups and resolutions), slave = the BHT.
interface lc3b_bht_if #(
    parameter int INDEX_BITS = 5
);
    logic [15:0]           lookup_pc;
    logic                  lookup_valid;
    logic                  predict_taken;
    logic [INDEX_BITS-1:0] lookup_index;
    logic                  update_valid;
    logic [INDEX_BITS-1:0] update_index;
    logic                  update_taken;
    logic                  update_mispredict;
    logic [15:0]           branch_count;
    logic [15:0]           mispredict_count;

    modport master (
        output lookup_pc, lookup_valid, update_valid, update_index,
               update_taken, update_mispredict,
        input  predict_taken, lookup_index, branch_count, mispredict_count
    );

    modport slave (
        input  lookup_pc, lookup_valid, update_valid, update_index,
               update_taken, update_mispredict,
        output predict_taken, lookup_index, branch_count, mispredict_count
    );
endinterface

// File: rtl/lc3b_bht.sv
// 2-bit saturating-counter branch history table with branch/mispredict stats.
// Optional BHT_GSHARE_EN folds a global history register into the lookup index.
module lc3b_bht #(
    parameter int INDEX_BITS = 5
) (
    input  logic        clk,
    input  logic        reset,
    lc3b_bht_if.slave   bus
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [ENTRIES-1:0][1:0] tbl_q, tbl_d;
    logic [15:0]             branch_cnt_q, branch_cnt_d;
    logic [15:0]             mispred_cnt_q, mispred_cnt_d;
    logic [INDEX_BITS-1:0]   idx;
    logic [1:0]              cur;
    logic                    unused_pc_bits;

    assign unused_pc_bits = ^{bus.lookup_pc[15:INDEX_BITS+1], bus.lookup_pc[0]};

`ifdef BHT_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr_q, ghr_d;

    always_comb begin
        ghr_d = ghr_q;
        if (bus.update_valid) ghr_d = {ghr_q[INDEX_BITS-2:0], bus.update_taken};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ghr_q <= '0;
        else       ghr_q <= ghr_d;
    end

    assign idx = bus.lookup_pc[INDEX_BITS:1] ^ ghr_q;
`else
    assign idx = bus.lookup_pc[INDEX_BITS:1];
`endif

    // Lookup reads the registered table, so a same-cycle update is not bypassed.
    assign bus.lookup_index     = idx;
    assign bus.predict_taken    = bus.lookup_valid & tbl_q[idx][1];
    assign bus.branch_count     = branch_cnt_q;
    assign bus.mispredict_count = mispred_cnt_q;

    assign cur = tbl_q[bus.update_index];

    always_comb begin
        tbl_d         = tbl_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (bus.update_valid) begin
            if (bus.update_taken) begin
                if (cur != 2'b11) tbl_d[bus.update_index] = cur + 2'b01;
            end else begin
                if (cur != 2'b00) tbl_d[bus.update_index] = cur - 2'b01;
            end
            if (branch_cnt_q != 16'hFFFF) branch_cnt_d = branch_cnt_q + 16'd1;
            if (bus.update_mispredict && mispred_cnt_q != 16'hFFFF)
                mispred_cnt_d = mispred_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= 2'b01;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            tbl_q         <= tbl_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end
endmodule
